tgt_tx_seq: RTL and testbench
=============================

TGT_TX_SEQ -- requirements
Module: tgt_tx_seq

Interface
REQ-001 SHALL have port i_sys_clk, input, 1: the single clock; all flops rise on it.
REQ-002 SHALL have port i_sys_rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port i_engine_start, input, 1: one-cycle request to send one HDR-DDR read response.
REQ-004 SHALL have port i_engine_word_cnt, input, 8: number of 16-bit data words, sampled with start.
REQ-005 SHALL have port i_engine_base_addr, input, 8: register-file address of the first byte, sampled with start.
REQ-006 SHALL have port i_engine_abort, input, 1: controller abort, level-sensitive.
REQ-007 SHALL have port i_tx_mode_done, input, 1: completion pulse from the target serializer.
REQ-008 SHALL have port o_tx_en, output, 1: serializer enable.
REQ-009 SHALL have port o_tx_mode, output, 3: serializer mode, coded as follows.
- PREAMBLE_ZERO = 000
- PREAMBLE_ONE = 001
- SERIALIZING_BYTE = 011
- CRC_TOKEN = 010
- PAR_VALUE = 110
- CRC_VALUE = 111
REQ-010 SHALL have port o_regf_rd_en, output, 1: register-file read strobe.
REQ-011 SHALL have port o_regf_addr, output, 8: register-file byte address.
REQ-012 SHALL have port o_crc_clr, output, 1: one-cycle clear pulse to the CRC5 engine.
REQ-013 SHALL have port o_engine_busy, output, 1: high whenever the FSM is not IDLE.
REQ-014 SHALL have port o_engine_done, output, 1: one-cycle pulse on normal completion.

Function
REQ-015 SHALL implement the FSM states IDLE, ACK, BYTE_HI, BYTE_LO, PAR, PRE_CONT, PRE_END, CRC_TOK and CRC_VAL.
REQ-016 SHALL drive these mode codes per state:
- ACK and PRE_END: 000
- PRE_CONT: 001
- BYTE_HI and BYTE_LO: 011
- PAR: 110
- CRC_TOK: 010
- CRC_VAL: 111
- IDLE: 000 with o_tx_en=0
REQ-017 SHALL, in IDLE on i_engine_start=1, do all of the following and enter ACK next cycle:
- latch word_cnt into a remaining-words counter
- latch base_addr into o_regf_addr
- pulse o_crc_clr in that same cycle
REQ-018 SHALL hold o_tx_en=1 in every non-IDLE state and change state only in a cycle where i_tx_mode_done=1; the new mode appears on the following cycle.
REQ-019 SHALL make these transitions on done:
- ACK -> BYTE_HI if remaining>0, else CRC_TOK
- BYTE_HI -> BYTE_LO
- BYTE_LO -> PAR
- PAR -> PRE_CONT if remaining>1, else PRE_END
- PRE_CONT -> BYTE_HI
- PRE_END -> CRC_TOK
- CRC_TOK -> CRC_VAL
- CRC_VAL -> IDLE
REQ-020 SHALL decrement the remaining counter on PAR done; the counter SHALL never underflow below 0.
REQ-021 SHALL assert o_regf_rd_en in BYTE_HI and BYTE_LO, and increment o_regf_addr by 1 (modulo 256; 0xFF wraps to 0x00) on each BYTE_HI/BYTE_LO done.
REQ-022 SHALL pulse o_engine_done for exactly one cycle in the cycle after CRC_VAL done, with o_tx_en=0 in that cycle.
REQ-023 SHALL ignore i_engine_start while o_engine_busy=1.
REQ-024 SHALL, on i_engine_abort=1 in any non-IDLE state, return to IDLE next cycle with o_tx_en=0, o_regf_rd_en=0 and no o_engine_done pulse; abort has priority over a simultaneous i_tx_mode_done.
REQ-025 SHALL, when i_engine_start and i_engine_abort are both 1 in IDLE, remain in IDLE.
REQ-026 SHALL ignore i_tx_mode_done in IDLE.

Reset
REQ-027 SHALL, while i_sys_rst=0, force the FSM to IDLE and the following outputs and counters immediately:
- o_tx_en=0, o_tx_mode=000, o_regf_rd_en=0, o_regf_addr=0x00
- o_crc_clr=0, o_engine_busy=0, o_engine_done=0
- remaining counter=0
REQ-028 SHALL, on reset assertion mid-response, abandon the response with no done pulse; after release, it SHALL wait for a fresh start.

Verification
REQ-029 SHALL cover: start with word_cnt=2, base=0x10, done pulsed per mode -> modes 000,011,011,110,001,011,011,110,000,010,111; addresses 0x10-0x13 read; one done pulse.
REQ-030 SHALL cover: start with word_cnt=0 -> modes 000,010,111, no o_regf_rd_en, done pulse.
REQ-031 SHALL cover: word_cnt=1, base=0xFF -> addresses 0xFF then 0x00; mode after PAR is 000 (PRE_END).
REQ-032 SHALL cover: abort asserted during the second BYTE_LO together with i_tx_mode_done -> IDLE next cycle, o_tx_en=0, no done.
REQ-033 SHALL cover: start pulsed while busy -> ignored, sequence unchanged.
REQ-034 SHALL cover: async reset asserted in CRC_TOK -> all outputs at reset values without a clock edge; a new start after release runs a full sequence.

Source files
------------

// File: rtl/tgt_tx_seq_if.sv
// tgt_tx_seq_if: engine request and serializer
// control bundle for the HDR-DDR read sequencer.
interface tgt_tx_seq_if;
  logic       i_engine_start;
  logic [7:0] i_engine_word_cnt;
  logic [7:0] i_engine_base_addr;
  logic       i_engine_abort;
  logic       i_tx_mode_done;
  logic       o_tx_en;
  logic [2:0] o_tx_mode;
  logic       o_regf_rd_en;
  logic [7:0] o_regf_addr;
  logic       o_crc_clr;
  logic       o_engine_busy;
  logic       o_engine_done;

  modport master (
    output i_engine_start,
    output i_engine_word_cnt,
    output i_engine_base_addr,
    output i_engine_abort,
    output i_tx_mode_done,
    input  o_tx_en,
    input  o_tx_mode,
    input  o_regf_rd_en,
    input  o_regf_addr,
    input  o_crc_clr,
    input  o_engine_busy,
    input  o_engine_done
  );

  modport slave (
    input  i_engine_start,
    input  i_engine_word_cnt,
    input  i_engine_base_addr,
    input  i_engine_abort,
    input  i_tx_mode_done,
    output o_tx_en,
    output o_tx_mode,
    output o_regf_rd_en,
    output o_regf_addr,
    output o_crc_clr,
    output o_engine_busy,
    output o_engine_done
  );
endinterface

// File: rtl/tgt_tx_seq.sv
// tgt_tx_seq: sequences serializer modes for
// one HDR-DDR read response (ACK, words, CRC).
module tgt_tx_seq (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  tgt_tx_seq_if.slave bus
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ACK      = 4'd1;
  localparam logic [3:0] BYTE_HI  = 4'd2;
  localparam logic [3:0] BYTE_LO  = 4'd3;
  localparam logic [3:0] PAR      = 4'd4;
  localparam logic [3:0] PRE_CONT = 4'd5;
  localparam logic [3:0] PRE_END  = 4'd6;
  localparam logic [3:0] CRC_TOK  = 4'd7;
  localparam logic [3:0] CRC_VAL  = 4'd8;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [7:0] remaining;
  logic [7:0] addr;
  logic       done_q;
  logic       idle;
  logic       go;
  logic       adv;
  logic       rd;

  assign idle = (state == IDLE);
  assign go   = idle & bus.i_engine_start
              & ~bus.i_engine_abort;
  assign adv  = ~idle & bus.i_tx_mode_done
              & ~bus.i_engine_abort;
  assign rd   = (state == BYTE_HI)
              | (state == BYTE_LO);

  // next-state: abort wins over done
  always_comb begin
    state_nxt = state;
    if (!idle && bus.i_engine_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (go) state_nxt = ACK;
        ACK:
          if (adv) state_nxt = (remaining != 8'd0)
                             ? BYTE_HI : CRC_TOK;
        BYTE_HI:
          if (adv) state_nxt = BYTE_LO;
        BYTE_LO:
          if (adv) state_nxt = PAR;
        PAR:
          if (adv) state_nxt = (remaining > 8'd1)
                             ? PRE_CONT : PRE_END;
        PRE_CONT:
          if (adv) state_nxt = BYTE_HI;
        PRE_END:
          if (adv) state_nxt = CRC_TOK;
        CRC_TOK:
          if (adv) state_nxt = CRC_VAL;
        CRC_VAL:
          if (adv) state_nxt = IDLE;
        default:
          state_nxt = IDLE;
      endcase
    end
  end

  // mode code decode from state
  always_comb begin
    bus.o_tx_mode = 3'b000;
    unique case (1'b1)
      (state == PRE_CONT): bus.o_tx_mode = 3'b001;
      rd:                  bus.o_tx_mode = 3'b011;
      (state == PAR):      bus.o_tx_mode = 3'b110;
      (state == CRC_TOK):  bus.o_tx_mode = 3'b010;
      (state == CRC_VAL):  bus.o_tx_mode = 3'b111;
      default:             bus.o_tx_mode = 3'b000;
    endcase
  end

  // state register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  // words left; saturates at zero
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst)
      remaining <= 8'd0;
    else if (go)
      remaining <= bus.i_engine_word_cnt;
    else if (adv && state == PAR && remaining != 8'd0)
      remaining <= remaining - 8'd1;
  end

  // byte address, wraps modulo 256
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst)
      addr <= 8'h00;
    else if (go)
      addr <= bus.i_engine_base_addr;
    else if (adv && rd)
      addr <= addr + 8'd1;
  end

  // completion pulse the cycle after CRC_VAL done
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) done_q <= 1'b0;
    else            done_q <= adv & (state == CRC_VAL);
  end

  assign bus.o_tx_en         = ~idle;
  assign bus.o_engine_busy   = ~idle;
  assign bus.o_regf_rd_en    = rd;
  assign bus.o_regf_addr     = addr;
  assign bus.o_crc_clr       = go;
  assign bus.o_engine_done   = done_q;
endmodule

// File: tb/tb_tgt_tx_seq.sv
// tb_tgt_tx_seq: vector table, corner sequences
// and random responses against a step-list model.
module tb_tgt_tx_seq;
  logic clk;
  logic rst;

  tgt_tx_seq_if bus ();

  tgt_tx_seq dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic       rd;
    logic [7:0] addr;
  } step_t;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] base;
    int         exp_steps;
    int         exp_rds;
    logic [7:0] exp_end_addr;
  } vec_t;

  int n_tests;
  int n_fail;
  int n_rd;
  logic [7:0] end_addr;
  logic [2:0] obs_mode[$];
  logic [7:0] obs_addr[$];

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic chk_reset_vals(string nm);
    chk({nm, "_tx_en"}, int'(bus.o_tx_en), 0);
    chk({nm, "_mode"}, int'(bus.o_tx_mode), 0);
    chk({nm, "_rd_en"}, int'(bus.o_regf_rd_en), 0);
    chk({nm, "_addr"}, int'(bus.o_regf_addr), 0);
    chk({nm, "_crc_clr"}, int'(bus.o_crc_clr), 0);
    chk({nm, "_busy"}, int'(bus.o_engine_busy), 0);
    chk({nm, "_done"}, int'(bus.o_engine_done), 0);
  endtask

  task automatic run(input logic [7:0] c,
                     input logic [7:0] b,
                     input int gmax,
                     input int abort_at,
                     input int rst_at,
                     input bit bstart);
    step_t q[$];
    obs_mode.delete();
    obs_addr.delete();
    n_rd = 0;
    q.push_back(step_t'{3'b000, 1'b0, 8'h00});
    for (int w = 0; w < int'(c); w++) begin
      q.push_back(step_t'{3'b011, 1'b1, 8'(int'(b) + 2 * w)});
      q.push_back(step_t'{3'b011, 1'b1, 8'(int'(b) + 2 * w + 1)});
      q.push_back(step_t'{3'b110, 1'b0, 8'h00});
      if (w < int'(c) - 1)
        q.push_back(step_t'{3'b001, 1'b0, 8'h00});
      else
        q.push_back(step_t'{3'b000, 1'b0, 8'h00});
    end
    q.push_back(step_t'{3'b010, 1'b0, 8'h00});
    q.push_back(step_t'{3'b111, 1'b0, 8'h00});

    @(negedge clk);
    bus.i_engine_start = 1'b1;
    bus.i_engine_word_cnt = c;
    bus.i_engine_base_addr = b;
    #1 chk("crc_clr_on_start", int'(bus.o_crc_clr), 1);
    @(negedge clk);
    bus.i_engine_start = 1'b0;
    bus.i_engine_word_cnt = 8'($urandom);
    bus.i_engine_base_addr = 8'($urandom);

    foreach (q[i]) begin
      int g;
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      for (int k = 0; k < g; k++) begin
        chk("hold_mode", int'(bus.o_tx_mode), int'(q[i].mode));
        @(negedge clk);
      end
      chk("mode", int'(bus.o_tx_mode), int'(q[i].mode));
      chk("tx_en", int'(bus.o_tx_en), 1);
      chk("busy", int'(bus.o_engine_busy), 1);
      chk("rd_en", int'(bus.o_regf_rd_en), int'(q[i].rd));
      if (q[i].rd)
        chk("addr", int'(bus.o_regf_addr), int'(q[i].addr));
      chk("done_early", int'(bus.o_engine_done), 0);
      obs_mode.push_back(bus.o_tx_mode);
      if (bus.o_regf_rd_en) begin
        obs_addr.push_back(bus.o_regf_addr);
        n_rd++;
      end
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_done", int'(bus.o_engine_done), 0);
        chk("rst_idle", int'(bus.o_engine_busy), 0);
        return;
      end
      if (i == abort_at) begin
        bus.i_engine_abort = 1'b1;
        bus.i_tx_mode_done = 1'b1;
        @(negedge clk);
        bus.i_engine_abort = 1'b0;
        bus.i_tx_mode_done = 1'b0;
        chk("abort_tx_en", int'(bus.o_tx_en), 0);
        chk("abort_rd_en", int'(bus.o_regf_rd_en), 0);
        chk("abort_busy", int'(bus.o_engine_busy), 0);
        chk("abort_done", int'(bus.o_engine_done), 0);
        @(negedge clk);
        chk("abort_done2", int'(bus.o_engine_done), 0);
        return;
      end
      bus.i_tx_mode_done = 1'b1;
      if (bstart) begin
        bus.i_engine_start = 1'b1;
        bus.i_engine_word_cnt = 8'($urandom);
        bus.i_engine_base_addr = 8'($urandom);
        #1 chk("busy_start_clr", int'(bus.o_crc_clr), 0);
      end
      @(negedge clk);
      bus.i_tx_mode_done = 1'b0;
      bus.i_engine_start = 1'b0;
    end
    chk("done_pulse", int'(bus.o_engine_done), 1);
    chk("done_tx_en", int'(bus.o_tx_en), 0);
    chk("done_busy", int'(bus.o_engine_busy), 0);
    end_addr = bus.o_regf_addr;
    @(negedge clk);
    chk("done_one_cycle", int'(bus.o_engine_done), 0);
  endtask

  vec_t tbl[5];
  logic [2:0] exp29[11];
  logic [7:0] a29[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    tbl[0] = '{8'd2, 8'h10, 11, 4, 8'h14};
    tbl[1] = '{8'd0, 8'h20, 3, 0, 8'h20};
    tbl[2] = '{8'd1, 8'hFF, 7, 2, 8'h01};
    tbl[3] = '{8'd3, 8'hFE, 15, 6, 8'h04};
    tbl[4] = '{8'd5, 8'h80, 23, 10, 8'h8A};
    exp29 = '{3'b000, 3'b011, 3'b011, 3'b110,
              3'b001, 3'b011, 3'b011, 3'b110,
              3'b000, 3'b010, 3'b111};
    a29 = '{8'h10, 8'h11, 8'h12, 8'h13};

    rst = 1'b0;
    bus.i_engine_start = 1'b0;
    bus.i_engine_word_cnt = 8'h00;
    bus.i_engine_base_addr = 8'h00;
    bus.i_engine_abort = 1'b0;
    bus.i_tx_mode_done = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    bus.i_tx_mode_done = 1'b1;
    @(negedge clk);
    bus.i_tx_mode_done = 1'b0;
    chk("idle_done_ignored", int'(bus.o_engine_busy), 0);
    bus.i_engine_start = 1'b1;
    bus.i_engine_abort = 1'b1;
    #1 chk("start_abort_clr", int'(bus.o_crc_clr), 0);
    @(negedge clk);
    bus.i_engine_start = 1'b0;
    bus.i_engine_abort = 1'b0;
    chk("start_abort_idle", int'(bus.o_engine_busy), 0);
    chk("start_abort_tx", int'(bus.o_tx_en), 0);

    for (int v = 0; v < 5; v++) begin
      run(tbl[v].cnt, tbl[v].base, 0, -1, -1, 1'b0);
      chk("tbl_steps", obs_mode.size(), tbl[v].exp_steps);
      chk("tbl_rds", n_rd, tbl[v].exp_rds);
      chk("tbl_end_addr", int'(end_addr),
          int'(tbl[v].exp_end_addr));
    end

    run(8'd2, 8'h10, 0, -1, -1, 1'b0);
    for (int i = 0; i < 11; i++)
      chk("seq29_mode", int'(obs_mode[i]), int'(exp29[i]));
    for (int i = 0; i < 4; i++)
      chk("seq29_addr", int'(obs_addr[i]), int'(a29[i]));

    run(8'd1, 8'hFF, 1, -1, -1, 1'b0);
    chk("wrap_addr0", int'(obs_addr[0]), 8'hFF);
    chk("wrap_addr1", int'(obs_addr[1]), 8'h00);
    chk("pre_end_mode", int'(obs_mode[4]), 0);

    run(8'd2, 8'h40, 0, 6, -1, 1'b0);
    chk("abort_steps", obs_mode.size(), 7);

    run(8'd2, 8'h10, 0, -1, -1, 1'b1);
    for (int i = 0; i < 11; i++)
      chk("busy_start_mode", int'(obs_mode[i]), int'(exp29[i]));

    run(8'd1, 8'h33, 0, -1, 5, 1'b0);
    chk("rst_at_tok", int'(obs_mode[5]), 3'b010);
    run(8'd2, 8'h10, 0, -1, -1, 1'b0);
    for (int i = 0; i < 11; i++)
      chk("post_rst_mode", int'(obs_mode[i]), int'(exp29[i]));

    for (int r = 0; r < 25; r++) begin
      run(8'($urandom_range(0, 8)), 8'($urandom), 2,
          -1, -1, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
